// File: rtl/clk_gen_pkg.sv
// rtl/clk_gen_pkg.sv - shared types and helpers for the machine-cycle timing generator
package clk_gen_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int unsigned MAX_PHASES = 64;

  function automatic logic [MAX_PHASES-1:0] onehot(input int unsigned k, input int unsigned phases);
    logic [MAX_PHASES-1:0] v;
    v = '0;
    if (k < phases) v = {{(MAX_PHASES-1){1'b0}}, 1'b1} << k;
    return v;
  endfunction

  function automatic int unsigned half_of(input int unsigned phases);
    return phases / 2;
  endfunction

endpackage

// File: rtl/clk_gen_phase_cnt.sv
// rtl/clk_gen_phase_cnt.sv - mod-PHASES phase counter with wrap flag and completed-cycle counter
module clk_gen_phase_cnt
  import clk_gen_pkg::*;
#(
  parameter int unsigned PHASES = 8,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned KW     = $clog2(PHASES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             active,
  input  logic             stall,
  output logic [KW-1:0]    k_q,
  output logic [KW-1:0]    k_next,
  output logic             wrap,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam logic [KW-1:0] K_LAST = KW'(PHASES - 1);

  logic [KW-1:0]    k_d;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             adv;

  always_comb begin
    adv   = active & ~stall;
    wrap  = adv & (k_q == K_LAST);
    k_d   = k_q;
    cnt_d = cnt_q;
    if (!active)  k_d = '0;
    else if (adv) k_d = wrap ? '0 : k_q + KW'(1);
    if (wrap)     cnt_d = cnt_q + CNT_W'(1);
    // An interrupted cycle is dropped, never counted
    if (!reset) begin
      k_d   = '0;
      cnt_d = '0;
    end
  end

  always_ff @(negedge clk) begin
    k_q   <= k_d;
    cnt_q <= cnt_d;
  end

  assign k_next    = k_d;
  assign cycle_cnt = cnt_q;

endmodule

// File: rtl/clk_gen_param.sv
// rtl/clk_gen_param.sv - machine-cycle timing generator; CLKGEN_STRETCH_EN adds a stall input
module clk_gen_param
  import clk_gen_pkg::*;
#(
  parameter int unsigned PHASES    = 8,
  parameter int unsigned ALU_PHASE = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
`ifdef CLKGEN_STRETCH_EN
  input  logic              stall,
`endif
  input  logic              reset,
  input  logic              run,
  input  logic              step,
  output logic              clk1,
  output logic              clk2,
  output logic              clk4,
  output logic              fetch,
  output logic              alu_clk,
  output logic [PHASES-1:0] phase,
  output logic              cycle_end,
  output logic              busy,
  output logic [CNT_W-1:0]  cycle_cnt
);

  localparam int unsigned   KW     = $clog2(PHASES);
  localparam logic [KW-1:0] K_LAST = KW'(PHASES - 1);
  localparam logic [KW-1:0] K_HALF = KW'(half_of(PHASES));
  localparam logic [KW-1:0] K_ALU  = KW'(ALU_PHASE);

  generate
    if (PHASES < 4 || (PHASES % 4) != 0 || PHASES > MAX_PHASES) begin : g_bad_phases
      $error("clk_gen_param: PHASES must be a multiple of 4 in 4..64");
    end
    if (ALU_PHASE >= PHASES) begin : g_bad_alu
      $error("clk_gen_param: ALU_PHASE must be below PHASES");
    end
  endgenerate

  logic stall_i;
`ifdef CLKGEN_STRETCH_EN
  assign stall_i = stall;
`else
  assign stall_i = 1'b0;
`endif

  state_e        state_d, state_q;
  logic [KW-1:0] k_q, k_next;
  logic          wrap, run_next;
  logic          clk2_d, clk2_q, clk4_d, clk4_q, fetch_d, fetch_q, alu_clk_d, alu_clk_q;

  clk_gen_phase_cnt #(
    .PHASES (PHASES),
    .CNT_W  (CNT_W),
    .KW     (KW)
  ) u_phase_cnt (
    .clk       (clk),
    .reset     (reset),
    .active    (state_q == RUN),
    .stall     (stall_i),
    .k_q       (k_q),
    .k_next    (k_next),
    .wrap      (wrap),
    .cycle_cnt (cycle_cnt)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (run || step) state_d = RUN;
      RUN:     if (wrap && !run) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (!reset) state_d = IDLE;

    // Outputs are registered from next-phase values so they line up with k_q
    run_next  = (state_d == RUN);
    clk2_d    = run_next & k_next[0];
    clk4_d    = ~run_next | ~k_next[1];
    fetch_d   = run_next & (k_next >= K_HALF);
    alu_clk_d = run_next & (k_next == K_ALU);
  end

  always_ff @(negedge clk) begin
    state_q   <= state_d;
    clk2_q    <= clk2_d;
    clk4_q    <= clk4_d;
    fetch_q   <= fetch_d;
    alu_clk_q <= alu_clk_d;
  end

  assign clk1      = ~clk;
  assign clk2      = clk2_q;
  assign clk4      = clk4_q;
  assign fetch     = fetch_q;
  assign alu_clk   = alu_clk_q;
  assign busy      = (state_q == RUN);
  assign cycle_end = busy & (k_q == K_LAST);
  assign phase     = busy ? PHASES'(onehot(int'(k_q), PHASES)) : '0;

endmodule

// File: tb/tb_clk_gen_param.sv
// tb/tb_clk_gen_param.sv - directed scoreboard bench for clk_gen_param (PHASES=8, ALU_PHASE=1)
module tb_clk_gen_param;

  logic        clk = 1'b1;
  logic        reset = 1'b0, run = 1'b0, step = 1'b0, stall = 1'b0;
  logic        clk1, clk2, clk4, fetch, alu_clk, cycle_end, busy;
  logic [7:0]  phase;
  logic [15:0] cycle_cnt;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic        busy;
    logic [7:0]  phase;
    logic        clk2;
    logic        clk4;
    logic        fetch;
    logic        alu;
    logic        cend;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];

  bit m_busy = 1'b0;
  int m_k    = 0;
  int m_cnt  = 0;

  always #5 clk = ~clk;

  clk_gen_param #(.PHASES(8), .ALU_PHASE(1), .CNT_W(16)) dut (
    .clk       (clk),
`ifdef CLKGEN_STRETCH_EN
    .stall     (stall),
`endif
    .reset     (reset),
    .run       (run),
    .step      (step),
    .clk1      (clk1),
    .clk2      (clk2),
    .clk4      (clk4),
    .fetch     (fetch),
    .alu_clk   (alu_clk),
    .phase     (phase),
    .cycle_end (cycle_end),
    .busy      (busy),
    .cycle_cnt (cycle_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t predict();
    exp_t e;
    logic [7:0] one;
    one     = 8'd1;
    e.busy  = m_busy;
    e.phase = m_busy ? (one << m_k) : 8'd0;
    e.clk2  = m_busy && (m_k % 2 == 1);
    e.clk4  = !m_busy || ((m_k / 2) % 2 == 0);
    e.fetch = m_busy && (m_k >= 4);
    e.alu   = m_busy && (m_k == 1);
    e.cend  = m_busy && (m_k == 7);
    e.cnt   = 16'(m_cnt);
    return e;
  endfunction

  task automatic tick(input logic r, input logic s, input logic rst);
    exp_t g;
    run   = r;
    step  = s;
    reset = rst;
    if (!rst) begin
      m_busy = 1'b0; m_k = 0; m_cnt = 0;
    end else if (!m_busy) begin
      if (r || s) begin m_busy = 1'b1; m_k = 0; end
    end else if (!stall) begin
      if (m_k == 7) begin
        m_cnt = (m_cnt + 1) % 65536;
        m_k   = 0;
        if (!r) m_busy = 1'b0;
      end else begin
        m_k++;
      end
    end
    sb.push_back(predict());
    @(negedge clk);
    @(posedge clk);
    g = sb.pop_front();
    chk("busy",      32'(busy),      32'(g.busy));
    chk("phase",     32'(phase),     32'(g.phase));
    chk("clk2",      32'(clk2),      32'(g.clk2));
    chk("clk4",      32'(clk4),      32'(g.clk4));
    chk("fetch",     32'(fetch),     32'(g.fetch));
    chk("alu_clk",   32'(alu_clk),   32'(g.alu));
    chk("cycle_end", 32'(cycle_end), 32'(g.cend));
    chk("cycle_cnt", 32'(cycle_cnt), 32'(g.cnt));
  endtask

  initial begin
    // reset then idle
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    repeat (4) tick(1'b0, 1'b0, 1'b1);
    chk("clk1_hi_clk", 32'(clk1), 32'(1'b0));
    #5;
    chk("clk1_lo_clk", 32'(clk1), 32'(1'b1));
    @(posedge clk);

    // free run for 24 negedges
    repeat (24) tick(1'b1, 1'b0, 1'b1);
    chk("run24_cnt", 32'(cycle_cnt), 32'd2);
    chk("run24_phase", 32'(phase), 32'h80);
    tick(1'b0, 1'b0, 1'b1);
    repeat (2) tick(1'b0, 1'b0, 1'b1);

    // single step with a second pulse mid-cycle
    tick(1'b0, 1'b1, 1'b1);
    repeat (3) tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b1, 1'b1);
    repeat (6) tick(1'b0, 1'b0, 1'b1);
    chk("step_cnt", 32'(cycle_cnt), 32'd4);
    chk("step_idle", 32'(busy), 32'd0);

    // run dropped at phase 04
    repeat (3) tick(1'b1, 1'b0, 1'b1);
    chk("drop_at_04", 32'(phase), 32'h04);
    repeat (6) tick(1'b0, 1'b0, 1'b1);
    chk("drop_cnt", 32'(cycle_cnt), 32'd5);

    // reset mid-cycle at phase 10
    repeat (5) tick(1'b1, 1'b0, 1'b1);
    chk("pre_reset_phase", 32'(phase), 32'h10);
    tick(1'b1, 1'b0, 1'b0);
    chk("reset_cnt", 32'(cycle_cnt), 32'd0);
    repeat (2) tick(1'b0, 1'b0, 1'b1);

    // step held high: back-to-back single cycles
    repeat (20) tick(1'b0, 1'b1, 1'b1);
    chk("held_step_cnt", 32'(cycle_cnt), 32'd2);

    // run and step together, then halt
    repeat (3) tick(1'b1, 1'b1, 1'b1);
    repeat (8) tick(1'b0, 1'b0, 1'b1);

`ifdef CLKGEN_STRETCH_EN
    repeat (4) tick(1'b1, 1'b0, 1'b1);
    stall = 1'b1;
    repeat (3) tick(1'b1, 1'b0, 1'b1);
    chk("stall_hold", 32'(phase), 32'h08);
    stall = 1'b0;
    tick(1'b1, 1'b0, 1'b1);
    chk("stall_resume", 32'(phase), 32'h10);
    repeat (4) tick(1'b0, 1'b0, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
